div: RTL



---
 rtl/div.sv | 114 +++++++++++
 1 files changed

// File: rtl/div.sv
// Sequential restoring unsigned divider: a 2W-bit dividend over a W-bit divisor,
// one quotient bit per clock, with a calc/rdy handshake that chains after the multiplier.
module div #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             calc,
  input  logic [2*W-1:0]   n,
  input  logic [W-1:0]     d,
  output logic [2*W-1:0]   q,
  output logic [W-1:0]     r,
  output logic             dz,
  output logic             rdy
);

  localparam int CW = $clog2(2*W);

  typedef enum logic {
    idle_s,
    calc_s
  } state_t;

  state_t         r_state;
  state_t         w_stateNext;
  logic [2*W-1:0] r_dividend;
  logic [W-1:0]   r_divisor;
  logic [W-1:0]   r_rem;
  logic [2*W-1:0] r_quot;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_q;
  logic [W-1:0]   r_r;
  logic           r_dz;
  logic           r_rdy;

  logic [W:0]     w_remShift;
  logic           w_ge;
  logic [W-1:0]   w_remNext;
  logic [2*W-1:0] w_quotNext;
  logic           w_last;

  // The stored remainder only needs W bits: the W+1-bit trial value exists only
  // for the compare, and a successful subtract always lands below 2^W.
  assign w_remShift = {r_rem, r_dividend[2*W-1]};
  assign w_ge       = w_remShift >= {1'b0, r_divisor};
  assign w_remNext  = w_ge ? (w_remShift[W-1:0] - r_divisor) : w_remShift[W-1:0];
  assign w_quotNext = {r_quot[2*W-2:0], w_ge};
  assign w_last     = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= idle_s;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      idle_s:  if (calc) w_stateNext = calc_s;
      calc_s:  if (w_last) w_stateNext = idle_s;
      default: w_stateNext = idle_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_cnt      <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_dz       <= 1'b0;
      r_rdy      <= 1'b0;
    end else begin
      case (r_state)
        idle_s: begin
          if (calc) begin
            r_dividend <= n;
            r_divisor  <= d;
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= CW'(2*W-1);
            r_rdy      <= 1'b0;
          end
        end
        calc_s: begin
          r_dividend <= {r_dividend[2*W-2:0], 1'b0};
          r_rem      <= w_remNext;
          r_quot     <= w_quotNext;
          // Results are published only here, so q/r/dz hold through the next run.
          if (w_last) begin
            r_q   <= w_quotNext;
            r_r   <= w_remNext;
            r_dz  <= (r_divisor == '0);
            r_rdy <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign q   = r_q;
  assign r   = r_r;
  assign dz  = r_dz;
  assign rdy = r_rdy && !calc;

endmodule
